// File: rtl/cmos_spi_slave.sv
// SPI mode-0 responder that serves 26-bit command frames from an internal 16-bit register file.
// SCLK/SS_N/MOSI are oversampled on clk_input; all decisions use the synchronized copies.
module cmos_spi_slave #(
  parameter int REG_DEPTH = 64
) (
  input  logic        clk_input,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_N,
  input  logic        MOSI,
  output logic        MISO,
  output logic        miso_oe,
  output logic        reg_wr_pulse,
  output logic [8:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        frame_error
);

  // state  | meaning
  // IDLE   | waiting for SS_N fall
  // ADDR   | address bits (SCLK rises 1..9)
  // RW     | read/write bit (rise 10)
  // DATA   | data bits (rises 11..26)
  // DONE   | more than 26 rises, frame will be rejected
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RW, S_DATA, S_DONE} state_t;

  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  state_t      state, state_nxt;
  logic [2:0]  sclk_sync, ss_sync;
  logic [1:0]  mosi_sync;
  logic [25:0] shift_reg;
  logic [4:0]  cnt, cnt_inc;
  logic [15:0] rd_shift, rd_word;
  logic        rd_armed;
  logic [15:0] regs [REG_DEPTH];

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, ss_active, mosi_bit;
  logic busy, clr_frame, shift_en, load_rd, out_en, end_frame, commit, err;

  // SS_N sync resets low so a select held low across reset release never looks like a fall
  always_ff @(posedge clk_input or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      ss_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], SCLK};
      ss_sync   <= {ss_sync[1:0], SS_N};
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign ss_rise   = ss_sync[1] & ~ss_sync[2];
  assign ss_fall   = ~ss_sync[1] & ss_sync[2];
  assign ss_active = ~ss_sync[1];
  assign mosi_bit  = mosi_sync[1];
  assign cnt_inc   = (cnt == 5'd31) ? cnt : cnt + 5'd1;

  always_comb begin
    rd_word = '0;
    if ({1'b0, shift_reg[8:0]} < 10'(REG_DEPTH))
      rd_word = regs[shift_reg[AW-1:0]];
  end

  always_ff @(posedge clk_input or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (ss_fall) state_nxt = S_ADDR;
      default: begin
        if (ss_rise)
          state_nxt = S_IDLE;
        else if (sclk_rise && ss_active) begin
          if (cnt_inc <= 5'd9)       state_nxt = S_ADDR;
          else if (cnt_inc == 5'd10) state_nxt = S_RW;
          else if (cnt_inc <= 5'd26) state_nxt = S_DATA;
          else                       state_nxt = S_DONE;
        end
      end
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    clr_frame = ((state == S_IDLE) && ss_fall) || (busy && ss_rise);
    shift_en  = busy && ss_active && sclk_rise;
    load_rd   = shift_en && (cnt == 5'd9) && !mosi_bit;
    out_en    = busy && ss_active && sclk_fall && rd_armed;
    end_frame = busy && ss_rise;
    commit    = end_frame && (cnt == 5'd26) && shift_reg[16];
    err       = end_frame && (cnt != 5'd26);
  end

  always_ff @(posedge clk_input or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg    <= '0;
      cnt          <= '0;
      rd_shift     <= '0;
      rd_armed     <= 1'b0;
      MISO         <= 1'b0;
      miso_oe      <= 1'b0;
      reg_wr_pulse <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
      frame_error  <= 1'b0;
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else begin
      reg_wr_pulse <= 1'b0;
      frame_error  <= err;
      if (clr_frame) begin
        shift_reg <= '0;
        cnt       <= '0;
        rd_shift  <= '0;
        rd_armed  <= 1'b0;
        MISO      <= 1'b0;
        miso_oe   <= 1'b0;
      end else begin
        if (shift_en) begin
          shift_reg <= {shift_reg[24:0], mosi_bit};
          cnt       <= cnt_inc;
        end
        if (load_rd) begin
          rd_shift <= rd_word;
          rd_armed <= 1'b1;
        end
        // zeros shift in behind the data, so MISO rests at 0 after bit 0
        if (out_en) begin
          miso_oe  <= 1'b1;
          MISO     <= rd_shift[15];
          rd_shift <= {rd_shift[14:0], 1'b0};
        end
      end
      if (commit) begin
        reg_wr_pulse <= 1'b1;
        reg_wr_addr  <= shift_reg[25:17];
        reg_wr_data  <= shift_reg[15:0];
        if ({1'b0, shift_reg[25:17]} < 10'(REG_DEPTH))
          regs[shift_reg[17+AW-1:17]] <= shift_reg[15:0];
      end
    end
  end

endmodule
